// File: rtl/lcd_byte_sequencer.sv
// lcd_byte_sequencer: hands the LCD bus from the init FSM to timed byte writes
module lcd_byte_sequencer #(
  parameter int SETUP_CYC  = 2,
  parameter int E_CYC      = 12,
  parameter int GAP_CYC    = 50,
  parameter int CMD_WAIT   = 2000,
  parameter int CLEAR_WAIT = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_done,
  input  logic [3:0] init_sf_d,
  input  logic       init_lcd_e,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       busy,
  output logic [3:0] sf_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw
);
  typedef enum logic [2:0] {INIT, IDLE, HI_SETUP, HI_E, HI_GAP, LO_SETUP, LO_E, LO_WAIT} state_t;

  // Every phase length must fit the 20-bit counter and be at least one cycle
  generate
    if (SETUP_CYC < 1 || SETUP_CYC >= 2**20 || E_CYC < 1 || E_CYC >= 2**20 ||
        GAP_CYC < 1 || GAP_CYC >= 2**20 || CMD_WAIT < 1 || CMD_WAIT >= 2**20 ||
        CLEAR_WAIT < 1 || CLEAR_WAIT >= 2**20) begin : g_bad_param
      $error("lcd_byte_sequencer: phase lengths must be in 1 .. 2^20-1");
    end
  endgenerate

  state_t      state;
  logic [19:0] cnt;
  logic [19:0] last;
  logic        rs_q;
  logic [7:0]  data_q;
  logic        clear_cmd;
  logic        in_init;
  logic        idle;
  logic        hi;
  logic        lo;

  // Phase end count; Clear Display / Return Home need the long execution wait
  always_comb begin
    clear_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
    last = (state == HI_SETUP || state == LO_SETUP) ? 20'(SETUP_CYC - 1) :
           (state == HI_E || state == LO_E)         ? 20'(E_CYC - 1) :
           (state == HI_GAP)                        ? 20'(GAP_CYC - 1) :
           clear_cmd                                ? 20'(CLEAR_WAIT - 1) : 20'(CMD_WAIT - 1);
  end

  // Phase sequencing; the counter restarts on every state entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= INIT;
      cnt    <= '0;
      rs_q   <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        INIT: if (init_done) begin
          state <= IDLE;
          cnt   <= '0;
        end
        IDLE: if (req_valid) begin
          state  <= HI_SETUP;
          cnt    <= '0;
          rs_q   <= req_rs;
          data_q <= req_data;
        end
        HI_SETUP, HI_E, HI_GAP, LO_SETUP, LO_E, LO_WAIT:
          if (cnt == last) begin
            state <= (state == LO_WAIT) ? IDLE : state_t'(state + 3'd1);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Bus drive decoded from state; init FSM owns the bus until handoff
  always_comb begin
    in_init   = state == INIT;
    idle      = state == IDLE;
    hi        = state == HI_SETUP || state == HI_E || state == HI_GAP;
    lo        = state == LO_SETUP || state == LO_E || state == LO_WAIT;
    sf_d      = in_init ? init_sf_d : hi ? data_q[7:4] : lo ? data_q[3:0] : 4'h0;
    lcd_e     = in_init ? init_lcd_e : (state == HI_E || state == LO_E);
    lcd_rs    = (hi || lo) && rs_q;
    lcd_rw    = 1'b0;
    req_ready = idle;
    busy      = !idle;
  end
endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// tb_lcd_byte_sequencer: random byte traffic checked against a per-cycle waveform model
module tb_lcd_byte_sequencer;
  localparam int S  = 2;
  localparam int E  = 12;
  localparam int G  = 50;
  localparam int CM = 200;
  localparam int CL = 820;

  logic       clk = 0;
  logic       reset_n;
  logic       init_done;
  logic [3:0] init_sf_d;
  logic       init_lcd_e;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       busy;
  logic [3:0] sf_d;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;

  int n_checks = 0;
  int n_fail = 0;

  lcd_byte_sequencer #(.SETUP_CYC(S), .E_CYC(E), .GAP_CYC(G), .CMD_WAIT(CM), .CLEAR_WAIT(CL)) dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done), .init_sf_d(init_sf_d),
    .init_lcd_e(init_lcd_e), .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .busy(busy), .sf_d(sf_d), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
  );

  always #5 clk = ~clk;

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? CL : CM;
  endfunction

  function automatic int byte_len(input logic rs, input logic [7:0] d);
    return 2 * S + 2 * E + G + wait_len(rs, d);
  endfunction

  // Expected {busy, req_ready, lcd_rs, lcd_e, sf_d} at cycle i after acceptance
  function automatic logic [7:0] exp_at(input int i, input logic rs, input logic [7:0] d);
    int len [6];
    int p;
    int t;
    len = '{S, E, G, S, E, wait_len(rs, d)};
    p = 0;
    t = i;
    while (p < 5 && t >= len[p]) begin
      t -= len[p];
      p++;
    end
    return {1'b1, 1'b0, rs, (p == 1 || p == 4), (p < 3) ? d[7:4] : d[3:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_byte(input logic rs, input logic [7:0] d, input bit hold, input bit noise);
    logic [7:0] ex;
    logic [7:0] got;
    logic [7:0] bad_ex;
    logic [7:0] bad_got;
    int total;
    int ehigh;
    int bad_i;
    bit ok;
    n_checks++;
    if ({busy, req_ready, lcd_rs, lcd_e, sf_d, lcd_rw} !== 9'b010000000) begin
      n_fail++;
      $display("FAIL idle_before_byte: got busy=%b ready=%b rs=%b e=%b sf_d=%h rw=%b, expected 0 1 0 0 0 0",
               busy, req_ready, lcd_rs, lcd_e, sf_d, lcd_rw);
    end
    req_valid = 1;
    req_rs = rs;
    req_data = d;
    tick();
    if (!hold) req_valid = 0;
    total = byte_len(rs, d);
    ok = 1;
    ehigh = 0;
    bad_i = 0;
    bad_ex = '0;
    bad_got = '0;
    for (int i = 0; i < total; i++) begin
      ex = exp_at(i, rs, d);
      got = {busy, req_ready, lcd_rs, lcd_e, sf_d};
      if (got !== ex && ok) begin
        ok = 0;
        bad_i = i;
        bad_ex = ex;
        bad_got = got;
      end
      ehigh += int'(lcd_e === 1'b1);
      if (noise) begin
        req_data = 8'($urandom);
        req_rs = 1'($urandom);
      end
      tick();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL byte_trace rs=%0b data=%h cycle %0d: got {busy,ready,rs,e,sf_d}=%b expected %b",
               rs, d, bad_i, bad_got, bad_ex);
    end
    n_checks++;
    if (ehigh != 2 * E) begin
      n_fail++;
      $display("FAIL strobe_width rs=%0b data=%h: got %0d lcd_e-high cycles, expected %0d", rs, d, ehigh, 2 * E);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    init_done = 0;
    req_valid = 0;
    req_rs = 0;
    req_data = 0;
    init_sf_d = 4'h3;
    init_lcd_e = 1;
    #3;
    n_checks++;
    if ({sf_d, lcd_e, req_ready, busy, lcd_rs, lcd_rw} !== 9'b0011_1_0_1_0_0) begin
      n_fail++;
      $display("FAIL reset_passthrough: got sf_d=%h e=%b ready=%b busy=%b rs=%b rw=%b, expected 3 1 0 1 0 0",
               sf_d, lcd_e, req_ready, busy, lcd_rs, lcd_rw);
    end
    init_sf_d = 0;
    init_lcd_e = 0;
    #1;
    n_checks++;
    if ({sf_d, lcd_e, req_ready, busy, lcd_rs, lcd_rw} !== 9'b0000_0_0_1_0_0) begin
      n_fail++;
      $display("FAIL reset_values: got sf_d=%h e=%b ready=%b busy=%b rs=%b rw=%b, expected 0 0 0 1 0 0",
               sf_d, lcd_e, req_ready, busy, lcd_rs, lcd_rw);
    end
    tick();
    reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      init_sf_d = 4'($urandom);
      init_lcd_e = 1'($urandom);
      tick();
      n_checks++;
      if (sf_d !== init_sf_d || lcd_e !== init_lcd_e || busy !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stay_in_init: got sf_d=%h e=%b busy=%b ready=%b, expected %h %b 1 0",
                 sf_d, lcd_e, busy, req_ready, init_sf_d, init_lcd_e);
      end
    end
  endtask

  task automatic test_handoff();
    init_sf_d = 4'hC;
    init_lcd_e = 1;
    init_done = 1;
    tick();
    init_done = 0;
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || sf_d !== 4'h0 || lcd_e !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff: got ready=%b busy=%b sf_d=%h e=%b, expected 1 0 0 0", req_ready, busy, sf_d, lcd_e);
    end
    init_sf_d = 0;
    init_lcd_e = 0;
  endtask

  task automatic test_data_byte();
    run_byte(1'b1, 8'h48, 0, 1);
  endtask

  task automatic test_wait_length();
    logic [7:0] codes [7] = '{8'h01, 8'h02, 8'h03, 8'h38, 8'h00, 8'h04, 8'h01};
    for (int i = 0; i < 7; i++) run_byte(i == 6, codes[i], 0, 0);
  endtask

  task automatic test_back_to_back();
    run_byte(1'b0, 8'h0C, 1, 1);
    run_byte(1'b1, 8'h5A, 1, 1);
    run_byte(1'b0, 8'h02, 0, 1);
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 20; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      run_byte(1'($urandom), d, (i != 19) && $urandom_range(0, 1) == 1, 1'($urandom));
    end
  endtask

  task automatic test_init_done_ignored();
    init_done = 0;
    repeat (5) tick();
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done_drop: got ready=%b busy=%b, expected 1 0", req_ready, busy);
    end
    run_byte(1'b1, 8'hE7, 0, 0);
  endtask

  task automatic test_reset_mid_byte();
    bit clean;
    req_valid = 1;
    req_rs = 1;
    req_data = 8'hA5;
    tick();
    req_valid = 0;
    repeat (S + 4) tick();
    n_checks++;
    if (lcd_e !== 1'b1 || sf_d !== 4'hA) begin
      n_fail++;
      $display("FAIL mid_byte_strobe: got e=%b sf_d=%h, expected 1 a", lcd_e, sf_d);
    end
    #2;
    init_lcd_e = 0;
    init_sf_d = 4'h9;
    reset_n = 0;
    #1;
    n_checks++;
    if (lcd_e !== 1'b0 || sf_d !== 4'h9 || busy !== 1'b1 || req_ready !== 1'b0 || lcd_rs !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got e=%b sf_d=%h busy=%b ready=%b rs=%b, expected 0 9 1 0 0",
               lcd_e, sf_d, busy, req_ready, lcd_rs);
    end
    init_lcd_e = 1;
    #1;
    n_checks++;
    if (lcd_e !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_follow_e: got e=%b, expected 1", lcd_e);
    end
    tick();
    init_lcd_e = 0;
    init_sf_d = 0;
    reset_n = 1;
    tick();
    init_done = 1;
    tick();
    init_done = 0;
    clean = 1;
    for (int i = 0; i < 30; i++) begin
      if (lcd_e !== 1'b0 || sf_d !== 4'h0 || req_ready !== 1'b1 || lcd_rs !== 1'b0) clean = 0;
      tick();
    end
    n_checks++;
    if (!clean) begin
      n_fail++;
      $display("FAIL residual_strobe: got e=%b sf_d=%h ready=%b rs=%b, expected 0 0 1 0", lcd_e, sf_d, req_ready, lcd_rs);
    end
    run_byte(1'b0, 8'h80, 0, 0);
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_data_byte();
    test_wait_length();
    test_back_to_back();
    test_random();
    test_init_done_ignored();
    test_reset_mid_byte();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
